// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin selection of one functional-unit result per
// cycle, broadcast on a registered tag/value bus, with flush and reserved-tag flagging.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 32,
  parameter int TAG_SIZE  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*TAG_SIZE-1:0]   req_tag,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
  input  logic                          flush,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          cdb_valid,
  output logic [TAG_SIZE-1:0]           cdb_tag,
  output logic [WORD_SIZE-1:0]          cdb_data,
  output logic                          tag_err,
  output logic [15:0]                   bcast_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Reserved tag: all ones below the MSB, meaning "value ready, no producer".
  localparam logic [TAG_SIZE-1:0] RSV_TAG = {1'b0, {(TAG_SIZE-1){1'b1}}};

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     idx;
  logic [PTR_W-1:0]     ptr_next;
  logic                 found;
  logic                 do_bcast;
  logic [NUM_REQ-1:0]   legal;
  logic [NUM_REQ-1:0]   rsv_hit;
  logic [TAG_SIZE-1:0]  win_tag;
  logic [WORD_SIZE-1:0] win_data;

  always_comb begin
    legal   = '0;
    rsv_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsv_hit[i] = req[i] && (req_tag[i*TAG_SIZE +: TAG_SIZE] == RSV_TAG);
      legal[i]   = req[i] && (req_tag[i*TAG_SIZE +: TAG_SIZE] != RSV_TAG);
    end
  end

  // Round-robin search starting at ptr; the first legal requester wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    win_tag  = '0;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && legal[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win) begin
        win_tag  = req_tag[i*TAG_SIZE +: TAG_SIZE];
        win_data = req_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign do_bcast = found && !flush;
  assign ptr_next = PTR_W'((int'(win) + 1) % NUM_REQ);

  always_comb begin
    grant = '0;
    if (do_bcast && !rst) grant[win] = 1'b1;
  end

  // Broadcast register stage: flush dominates any pending winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= RSV_TAG;
      cdb_data  <= '0;
      tag_err   <= 1'b0;
      bcast_cnt <= '0;
    end else begin
      if (|rsv_hit) tag_err <= 1'b1;
      if (flush) begin
        cdb_valid <= 1'b0;
        ptr       <= '0;
      end else if (found) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= win_tag;
        cdb_data  <= win_data;
        ptr       <= ptr_next;
        bcast_cnt <= bcast_cnt + 16'd1;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of per-cycle vectors plus hand-written
// sequences for asynchronous reset mid-broadcast and broadcast-counter wrap.
module tb_cdb_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  req_tag;
  logic [127:0] req_data;
  logic         flush;
  logic [3:0]   grant;
  logic         cdb_valid;
  logic [7:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic         tag_err;
  logic [15:0]  bcast_cnt;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.NUM_REQ(4), .WORD_SIZE(32), .TAG_SIZE(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_data(req_data),
    .flush(flush), .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .tag_err(tag_err), .bcast_cnt(bcast_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   req;
    logic [31:0]  tags;
    logic [127:0] data;
    logic         flush;
    logic [3:0]   g;
    logic         v;
    logic [7:0]   t;
    logic [31:0]  d;
    logic [15:0]  c;
    logic         e;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0]  T4 = 32'h04030201;
  localparam logic [127:0] D4 = {32'd400, 32'd300, 32'd200, 32'd100};
  localparam logic [31:0]  T2 = 32'h00090000;
  localparam logic [127:0] D2 = {32'd0, 32'hFFFFFFF9, 64'd0};
  localparam logic [31:0]  TR = 32'h0000057F;
  localparam logic [127:0] DR = {64'd0, 32'd55, 32'd0};

  function automatic vec_t mk(logic [3:0] r, logic [31:0] tg, logic [127:0] dt, logic f,
                              logic [3:0] g, logic v, logic [7:0] t, logic [31:0] d,
                              logic [15:0] c, logic e);
    vec_t x;
    x.req = r; x.tags = tg; x.data = dt; x.flush = f;
    x.g = g; x.v = v; x.t = t; x.d = d; x.c = c; x.e = e;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(string pfx, logic v, logic [7:0] t, logic [31:0] d,
                          logic [15:0] c, logic e);
    chk({pfx, " valid"}, 32'(cdb_valid), 32'(v));
    chk({pfx, " tag"},   32'(cdb_tag),   32'(t));
    chk({pfx, " data"},  cdb_data,       d);
    chk({pfx, " cnt"},   32'(bcast_cnt), 32'(c));
    chk({pfx, " err"},   32'(tag_err),   32'(e));
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; req_tag = T4; req_data = D4; flush = 1'b0;

    // Reset state, with requests present that must not be granted.
    #2;
    chk("reset grant", 32'(grant), 32'h0);
    chk_regs("reset", 1'b0, 8'h7F, 32'h0, 16'h0, 1'b0);
    req = 4'b0000;
    #6 rst = 1'b0;
    @(posedge clk); #1;

    // All four requesting, then single requester, reserved tag, flush, ptr wrap.
    tbl.push_back(mk(4'b1111, T4, D4, 1'b0, 4'b0001, 1'b1, 8'd1, 32'd100, 16'd1, 1'b0));
    tbl.push_back(mk(4'b1111, T4, D4, 1'b0, 4'b0010, 1'b1, 8'd2, 32'd200, 16'd2, 1'b0));
    tbl.push_back(mk(4'b1111, T4, D4, 1'b0, 4'b0100, 1'b1, 8'd3, 32'd300, 16'd3, 1'b0));
    tbl.push_back(mk(4'b1111, T4, D4, 1'b0, 4'b1000, 1'b1, 8'd4, 32'd400, 16'd4, 1'b0));
    tbl.push_back(mk(4'b1111, T4, D4, 1'b0, 4'b0001, 1'b1, 8'd1, 32'd100, 16'd5, 1'b0));
    tbl.push_back(mk(4'b0100, T2, D2, 1'b0, 4'b0100, 1'b1, 8'd9, 32'hFFFFFFF9, 16'd6, 1'b0));
    tbl.push_back(mk(4'b0100, T2, D2, 1'b0, 4'b0100, 1'b1, 8'd9, 32'hFFFFFFF9, 16'd7, 1'b0));
    tbl.push_back(mk(4'b0100, T2, D2, 1'b0, 4'b0100, 1'b1, 8'd9, 32'hFFFFFFF9, 16'd8, 1'b0));
    tbl.push_back(mk(4'b0000, T2, D2, 1'b0, 4'b0000, 1'b0, 8'd9, 32'hFFFFFFF9, 16'd8, 1'b0));
    tbl.push_back(mk(4'b0011, TR, DR, 1'b0, 4'b0010, 1'b1, 8'd5, 32'd55, 16'd9, 1'b1));
    tbl.push_back(mk(4'b0001, TR, DR, 1'b0, 4'b0000, 1'b0, 8'd5, 32'd55, 16'd9, 1'b1));
    tbl.push_back(mk(4'b0000, TR, DR, 1'b0, 4'b0000, 1'b0, 8'd5, 32'd55, 16'd9, 1'b1));
    tbl.push_back(mk(4'b1111, T4, D4, 1'b1, 4'b0000, 1'b0, 8'd5, 32'd55, 16'd9, 1'b1));
    tbl.push_back(mk(4'b1111, T4, D4, 1'b0, 4'b0001, 1'b1, 8'd1, 32'd100, 16'd10, 1'b1));
    tbl.push_back(mk(4'b1001, T4, D4, 1'b0, 4'b1000, 1'b1, 8'd4, 32'd400, 16'd11, 1'b1));
    tbl.push_back(mk(4'b1001, T4, D4, 1'b0, 4'b0001, 1'b1, 8'd1, 32'd100, 16'd12, 1'b1));

    foreach (tbl[i]) begin
      req = tbl[i].req; req_tag = tbl[i].tags; req_data = tbl[i].data; flush = tbl[i].flush;
      #2;
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].g));
      @(posedge clk); #1;
      chk_regs($sformatf("v%0d", i), tbl[i].v, tbl[i].t, tbl[i].d, tbl[i].c, tbl[i].e);
    end

    // Asynchronous reset while broadcasting takes effect without a clock edge.
    req = 4'b1111; req_tag = T4; req_data = D4; flush = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset valid", 32'(cdb_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async grant", 32'(grant), 32'h0);
    chk_regs("async", 1'b0, 8'h7F, 32'h0, 16'h0, 1'b0);
    req = 4'b0000;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    req = 4'b1111;
    #2;
    chk("post-reset grant", 32'(grant), 32'h1);
    @(posedge clk); #1;
    chk_regs("post-reset", 1'b1, 8'd1, 32'd100, 16'd1, 1'b0);

    // Counter wrap: 65535 more back-to-back broadcasts from a single requester.
    req = 4'b0100; req_tag = T2; req_data = D2;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt max", 32'(bcast_cnt), 32'hFFFF);
    #1;
    chk("wrap grant", 32'(grant), 32'h4);
    @(posedge clk); #1;
    chk_regs("wrap", 1'b1, 8'd9, 32'hFFFFFFF9, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
